// File: rtl/instr_fetch_unit_pkg.sv
// fetch_pkg: shared widths, FIFO entry type and request FSM states for the fetch front end
package fetch_pkg;
  localparam int PC_W = 8;
  localparam int INSTR_W = 32;
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
  typedef enum logic [1:0] {IDLE, REQ, STALL} fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory req/gnt/rvalid bus plus decode valid/ready handshake
interface instr_fetch_unit_if;
  import fetch_pkg::*;
  logic               imem_req_o;
  logic [PC_W-1:0]    imem_addr_o;
  logic               imem_gnt_i;
  logic               imem_rvalid_i;
  logic [INSTR_W-1:0] imem_rdata_i;
  logic               instr_valid_o;
  logic [INSTR_W-1:0] instr_o;
  logic [PC_W-1:0]    instr_pc_o;
  logic               instr_ready_i;
  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
  );
  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
  );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: DEPTH-entry prefetch FIFO of {pc, instr} with flush, count and registered storage
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  fetch_entry_t                 entry_i,
  output fetch_entry_t                 head_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return p == PTR_W'(DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction
  always_comb begin
    mem_d = mem_q;
    if (push_i && !flush_i) mem_d[wr_q] = entry_i;
    wr_d  = flush_i ? '0 : push_i ? nxt(wr_q) : wr_q;
    rd_d  = flush_i ? '0 : pop_i ? nxt(rd_q) : rd_q;
    cnt_d = flush_i ? '0 : cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  assign head_o  = mem_q[rd_q];
  assign valid_o = cnt_q != '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-limited instruction fetch with prefetch FIFO, back-pressure and redirect
module instr_fetch_unit import fetch_pkg::*; #(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fetch_en_i,
  input  logic             redirect_i,
  input  logic [PC_W-1:0]  redirect_pc_i,
  instr_fetch_unit_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  fetch_state_t state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] out_q, out_d, discard_q, discard_d, count, count_d;
  logic gnt, push, pop, credit_d, head_valid;
  fetch_entry_t entry, head;
  assign gnt   = state_q == REQ && bus.imem_gnt_i;
  assign push  = bus.imem_rvalid_i && discard_q == '0;
  assign pop   = head_valid && bus.instr_ready_i && !redirect_i;
  assign entry = {resp_pc_q, bus.imem_rdata_i};
  // Credit is judged on next-cycle totals so a raised request always has room for its response
  always_comb begin
    out_d      = out_q + CNT_W'(gnt) - CNT_W'(bus.imem_rvalid_i);
    count_d    = redirect_i ? '0 : count + CNT_W'(push) - CNT_W'(pop);
    credit_d   = {1'b0, count_d} + {1'b0, out_d} < (CNT_W+1)'(DEPTH);
    fetch_pc_d = redirect_i ? redirect_pc_i : gnt ? fetch_pc_q + PC_W'(1) : fetch_pc_q;
    resp_pc_d  = redirect_i ? redirect_pc_i : push ? resp_pc_q + PC_W'(1) : resp_pc_q;
    discard_d  = redirect_i ? out_d : discard_q - CNT_W'(bus.imem_rvalid_i && discard_q != '0);
    state_d    = redirect_i ? IDLE :
                 state_q == IDLE ? (fetch_en_i && credit_d ? REQ : IDLE) :
                 state_q == REQ  ? (!gnt ? REQ : !fetch_en_i ? IDLE : credit_d ? REQ : STALL) :
                 (!fetch_en_i ? IDLE : credit_d ? REQ : STALL);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
    end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (push),
    .pop_i   (pop),
    .entry_i (entry),
    .head_o  (head),
    .valid_o (head_valid),
    .count_o (count)
  );
  assign bus.imem_req_o    = state_q == REQ;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = head_valid;
  assign bus.instr_o       = head.instr;
  assign bus.instr_pc_o    = head.pc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch issue, back-pressure, grant delay, redirect, wrap and reset
module tb_instr_fetch_unit;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       fetch_en_i = 1'b0;
  logic       redirect_i = 1'b0;
  logic [7:0] redirect_pc_i = '0;
  int n_chk = 0, n_pass = 0, n_gnt = 0;
  int lat_cfg = 1, gnt_delay = 0, cyc = 0;
  typedef struct {int due; logic [7:0] addr;} rsp_t;
  rsp_t rsp_q[$];

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fetch_en_i    (fetch_en_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .bus           (bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    int  wait_cnt;
    logic prev_wait;
    wait_cnt = 0;
    prev_wait = 1'b0;
    bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      cyc++;
      if (!rst_ni) begin
        rsp_q.delete();
        wait_cnt = 0;
        prev_wait = 1'b0;
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = '0;
      end else begin
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
          bus.imem_rvalid_i = 1'b1;
          bus.imem_rdata_i = 32'h100 + 32'(rsp_q[0].addr);
          void'(rsp_q.pop_front());
        end else begin
          bus.imem_rvalid_i = 1'b0;
          bus.imem_rdata_i = '0;
        end
        wait_cnt = prev_wait ? wait_cnt + 1 : 0;
        bus.imem_gnt_i = bus.imem_req_o && wait_cnt >= gnt_delay;
        prev_wait = bus.imem_req_o && !bus.imem_gnt_i;
        if (bus.imem_req_o && bus.imem_gnt_i) begin
          rsp_q.push_back('{due: cyc + lat_cfg, addr: bus.imem_addr_o});
          n_gnt++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset(input int lat, input int gd, input logic rdy);
    rst_ni = 1'b0;
    fetch_en_i = 1'b0;
    redirect_i = 1'b0;
    bus.instr_ready_i = rdy;
    lat_cfg = lat;
    gnt_delay = gd;
    repeat (2) tick();
    n_gnt = 0;
    rst_ni = 1'b1;
    fetch_en_i = 1'b1;
  endtask

  task automatic drain(input int n, input logic [7:0] pc0, input string tag);
    int got;
    logic [7:0] epc;
    got = 0;
    for (int c = 0; c < 60 && got < n; c++) begin
      @(negedge clk_i);
      if (bus.instr_valid_o && bus.instr_ready_i) begin
        epc = pc0 + 8'(got);
        check({tag, "_pc"}, bus.instr_pc_o, epc);
        check({tag, "_instr"}, bus.instr_o, 32'h100 + 32'(epc));
        got++;
      end
    end
    check({tag, "_count"}, got, n);
  endtask

  initial begin
    bus.instr_ready_i = 1'b1;
    // reset values
    repeat (2) tick();
    @(negedge clk_i);
    check("rst_req", bus.imem_req_o, 0);
    check("rst_addr", bus.imem_addr_o, 0);
    check("rst_valid", bus.instr_valid_o, 0);
    check("rst_instr", bus.instr_o, 0);
    check("rst_pc", bus.instr_pc_o, 0);

    // streaming at one instruction per cycle from cycle 3
    do_reset(1, 0, 1'b1);
    repeat (2) tick();
    @(negedge clk_i);
    check("t1_latency_valid", bus.instr_valid_o, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      check("t1_valid", bus.instr_valid_o, 1);
      check("t1_pc", bus.instr_pc_o, i);
      check("t1_instr", bus.instr_o, 32'h100 + i);
      tick();
    end

    // back-pressure fills the credits, then drains in order
    do_reset(1, 0, 1'b0);
    repeat (10) tick();
    @(negedge clk_i);
    check("t2_grants", n_gnt, 4);
    check("t2_req_stall", bus.imem_req_o, 0);
    check("t2_head_valid", bus.instr_valid_o, 1);
    check("t2_head_pc", bus.instr_pc_o, 0);
    check("t2_head_instr", bus.instr_o, 32'h100);
    tick();
    bus.instr_ready_i = 1'b1;
    drain(8, 8'h00, "t2");

    // delayed grant keeps the request stable
    do_reset(1, 3, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("t3_req_hold", bus.imem_req_o, 1);
      check("t3_addr_hold", bus.imem_addr_o, 0);
      check("t3_no_grant", n_gnt, 0);
      tick();
    end
    tick();
    @(negedge clk_i);
    check("t3_grants", n_gnt, 1);
    check("t3_next_addr", bus.imem_addr_o, 1);
    drain(2, 8'h00, "t3");

    // redirect with two requests in flight discards both responses
    do_reset(3, 0, 1'b1);
    tick();
    tick();
    fetch_en_i = 1'b0;
    tick();
    redirect_i = 1'b1;
    redirect_pc_i = 8'h40;
    fetch_en_i = 1'b1;
    @(negedge clk_i);
    check("t4_inflight", n_gnt, 2);
    check("t4_idle", bus.imem_req_o, 0);
    tick();
    redirect_i = 1'b0;
    @(negedge clk_i);
    check("t4_flushed", bus.instr_valid_o, 0);
    check("t4_addr", bus.imem_addr_o, 8'h40);
    drain(1, 8'h40, "t4");

    // redirect of a full FIFO, then PC wrap 0xFF -> 0x00
    do_reset(1, 0, 1'b0);
    repeat (10) tick();
    @(negedge clk_i);
    check("t5_full_valid", bus.instr_valid_o, 1);
    tick();
    redirect_i = 1'b1;
    redirect_pc_i = 8'hFE;
    tick();
    redirect_i = 1'b0;
    @(negedge clk_i);
    check("t5_flushed", bus.instr_valid_o, 0);
    check("t5_addr", bus.imem_addr_o, 8'hFE);
    tick();
    bus.instr_ready_i = 1'b1;
    drain(4, 8'hFE, "t5");

    // asynchronous reset mid-stream
    do_reset(1, 0, 1'b0);
    repeat (5) tick();
    @(negedge clk_i);
    check("t6_pre_valid", bus.instr_valid_o, 1);
    check("t6_pre_instr", bus.instr_o, 32'h100);
    rst_ni = 1'b0;
    #1;
    check("t6_req", bus.imem_req_o, 0);
    check("t6_addr", bus.imem_addr_o, 0);
    check("t6_valid", bus.instr_valid_o, 0);
    check("t6_instr", bus.instr_o, 0);
    check("t6_pc", bus.instr_pc_o, 0);
    repeat (2) tick();
    rst_ni = 1'b1;
    bus.instr_ready_i = 1'b1;
    repeat (3) tick();
    @(negedge clk_i);
    check("t6_restart_valid", bus.instr_valid_o, 1);
    check("t6_restart_pc", bus.instr_pc_o, 0);
    check("t6_restart_instr", bus.instr_o, 32'h100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
